// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared FSM encoding, reset-cause codes and counter sizing for rst_seq_sync.
package rst_seq_pkg;
    typedef enum logic [1:0] {S_HOLD, S_STRETCH, S_RELEASE, S_DONE} state_t;
    localparam logic [1:0] CAUSE_HW = 2'b01;
    localparam logic [1:0] CAUSE_SW = 2'b10;
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rst_sync_chain.sv
// rst_sync_chain: async-assert, sync-deassert reset synchroniser of NUM_STAGES flops.
module rst_sync_chain #(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    output logic SYNC_OUT
);
    logic [NUM_STAGES-1:0] chain;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) chain <= '0;
        else chain <= {chain[NUM_STAGES-2:0], 1'b1};
    end
    assign SYNC_OUT = chain[NUM_STAGES-1];
endmodule

// File: rtl/rst_seq_sync.sv
// rst_seq_sync: reset synchroniser that stretches reset, then releases NUM_OUTS resets in order.
// Define RST_SEQ_CAUSE_EN to add the RST_CAUSE output (01 = RST, 10 = software).
module rst_seq_sync
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 2,
    parameter int NUM_OUTS       = 3,
    parameter int STRETCH_CYCLES = 16,
    parameter int GAP_CYCLES     = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                SW_RST_REQ,
    output logic [NUM_OUTS-1:0] SYNC_RST,
    output logic                RST_DONE
`ifdef RST_SEQ_CAUSE_EN
    ,
    output logic [1:0]          RST_CAUSE
`endif
);
    localparam int CW = cnt_width((STRETCH_CYCLES > GAP_CYCLES ? STRETCH_CYCLES : GAP_CYCLES) + 1);
    localparam int IW = cnt_width(NUM_OUTS);
    state_t              state, state_d;
    logic [CW-1:0]       cnt, cnt_d;
    logic [IW-1:0]       idx, idx_d;
    logic [NUM_OUTS-1:0] sync_d;
    logic                done_d, rst_sync_n, sw_ok, stretching;
    rst_sync_chain #(.NUM_STAGES(NUM_STAGES)) u_chain (
        .CLK      (CLK),
        .RST      (RST),
        .SYNC_OUT (rst_sync_n)
    );
    assign sw_ok = SW_RST_REQ && state != S_HOLD;
    // The edge that first sees rst_sync_n high already counts as stretch cycle one.
    assign stretching = state == S_STRETCH || (state == S_HOLD && rst_sync_n);
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        sync_d  = SYNC_RST;
        done_d  = RST_DONE;
        if (sw_ok) begin
            state_d = S_STRETCH;
            cnt_d   = '0;
            idx_d   = '0;
            sync_d  = '0;
            done_d  = 1'b0;
        end else if (stretching) begin
            state_d = S_STRETCH;
            cnt_d   = cnt + 1'b1;
            if (cnt == CW'(STRETCH_CYCLES - 1)) begin
                cnt_d   = '0;
                sync_d  = NUM_OUTS'({SYNC_RST, 1'b1});
                state_d = (NUM_OUTS == 1) ? S_DONE : S_RELEASE;
                done_d  = NUM_OUTS == 1;
            end
        end else if (state == S_RELEASE) begin
            cnt_d = cnt + 1'b1;
            if (cnt == CW'(GAP_CYCLES - 1)) begin
                cnt_d   = '0;
                idx_d   = idx + 1'b1;
                sync_d  = NUM_OUTS'({SYNC_RST, 1'b1});
                state_d = (idx == IW'(NUM_OUTS - 2)) ? S_DONE : S_RELEASE;
                done_d  = idx == IW'(NUM_OUTS - 2);
            end
        end
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_HOLD;
            cnt      <= '0;
            idx      <= '0;
            SYNC_RST <= '0;
            RST_DONE <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            idx      <= idx_d;
            SYNC_RST <= sync_d;
            RST_DONE <= done_d;
        end
    end
`ifdef RST_SEQ_CAUSE_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) RST_CAUSE <= CAUSE_HW;
        else RST_CAUSE <= sw_ok ? CAUSE_SW : RST_CAUSE;
    end
`endif
endmodule
